// File: rtl/output_arbiter.sv
// Three-input round-robin arbiter (cw, ccw, pe) feeding a single-entry output register.
// Define OUTPUT_ARBITER_HOP_DEC_EN to decrement (saturating) the hop field on capture.
module output_arbiter #(
    parameter int DATA_W  = 64,
    parameter int HOP_LSB = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arb_en,
    input  logic [2:0]            req_si,
    input  logic [3*DATA_W-1:0]   req_di,
    output logic [2:0]            req_ri,
    output logic                  out_so,
    input  logic                  out_ro,
    output logic [DATA_W-1:0]     out_do
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] out_do_q, out_do_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;

    logic [1:0]        ptr_eff;
    logic [2:0]        grant;
    logic [1:0]        grant_idx;
    logic              can_accept;
    logic              rel;
    logic              capture;
    logic [DATA_W-1:0] sel_flit;
    logic [DATA_W-1:0] stored_flit;
`ifdef OUTPUT_ARBITER_HOP_DEC_EN
    logic [7:0]        hop;
`endif

    // An out-of-range pointer value of 3 behaves exactly like 0.
    always_comb begin
        ptr_eff   = (rr_ptr_q == 2'd3) ? 2'd0 : rr_ptr_q;
        grant     = 3'b000;
        grant_idx = 2'd0;
        case (ptr_eff)
            2'd1: begin
                if (req_si[1])      begin grant = 3'b010; grant_idx = 2'd1; end
                else if (req_si[2]) begin grant = 3'b100; grant_idx = 2'd2; end
                else if (req_si[0]) begin grant = 3'b001; grant_idx = 2'd0; end
            end
            2'd2: begin
                if (req_si[2])      begin grant = 3'b100; grant_idx = 2'd2; end
                else if (req_si[0]) begin grant = 3'b001; grant_idx = 2'd0; end
                else if (req_si[1]) begin grant = 3'b010; grant_idx = 2'd1; end
            end
            default: begin
                if (req_si[0])      begin grant = 3'b001; grant_idx = 2'd0; end
                else if (req_si[1]) begin grant = 3'b010; grant_idx = 2'd1; end
                else if (req_si[2]) begin grant = 3'b100; grant_idx = 2'd2; end
            end
        endcase
    end

    always_comb begin
        can_accept = arb_en & (~state_q[0] | out_ro);
        rel        = arb_en & state_q[0] & out_ro;
        req_ri     = reset ? 3'b000 : (grant & {3{can_accept}});
        capture    = |req_ri;
    end

    always_comb begin
        case (grant_idx)
            2'd1:    sel_flit = req_di[1*DATA_W +: DATA_W];
            2'd2:    sel_flit = req_di[2*DATA_W +: DATA_W];
            default: sel_flit = req_di[0 +: DATA_W];
        endcase
    end

`ifdef OUTPUT_ARBITER_HOP_DEC_EN
    // Hop count saturates at zero rather than wrapping to 8'hFF.
    always_comb begin
        hop         = sel_flit[HOP_LSB +: 8];
        stored_flit = sel_flit;
        if (hop != 8'd0) begin
            stored_flit[HOP_LSB +: 8] = hop - 8'd1;
        end
    end
`else
    always_comb begin
        stored_flit = sel_flit;
    end
`endif

    // A capture wins over a release, giving bubble-free pass-through when FULL.
    always_comb begin
        state_d  = state_q;
        out_do_d = out_do_q;
        rr_ptr_d = rr_ptr_q;
        if (capture) begin
            state_d  = FULL;
            out_do_d = stored_flit;
            case (grant_idx)
                2'd0:    rr_ptr_d = 2'd1;
                2'd1:    rr_ptr_d = 2'd2;
                default: rr_ptr_d = 2'd0;
            endcase
        end else if (rel) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            out_do_q <= '0;
            rr_ptr_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            out_do_q <= out_do_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_so = state_q[0];
    assign out_do = out_do_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: directed vector table, hop-field sequences,
// and randomized traffic compared against a behavioural model.
module tb_output_arbiter;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              arb_en;
    logic [2:0]        req_si;
    logic [3*DATA_W-1:0] req_di;
    logic [2:0]        req_ri;
    logic              out_so;
    logic              out_ro;
    logic [DATA_W-1:0] out_do;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic [2:0]  req;
        logic        ro;
        logic [63:0] base;
        logic [2:0]  exp_rr;
        logic        exp_so;
        logic [63:0] exp_do;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    output_arbiter #(.DATA_W(DATA_W), .HOP_LSB(48)) dut (
        .clk    (clk),
        .reset  (reset),
        .arb_en (arb_en),
        .req_si (req_si),
        .req_di (req_di),
        .req_ri (req_ri),
        .out_so (out_so),
        .out_ro (out_ro),
        .out_do (out_do)
    );

    task automatic applyStimulus(input logic rst, input logic en, input logic [2:0] req,
                                 input logic ro, input logic [63:0] f0,
                                 input logic [63:0] f1, input logic [63:0] f2);
        reset  = rst;
        arb_en = en;
        req_si = req;
        out_ro = ro;
        req_di = {f2, f1, f0};
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_store(input logic [63:0] f);
        logic [63:0] r;
        r = f;
`ifdef OUTPUT_ARBITER_HOP_DEC_EN
        if (f[55:48] != 8'd0) r[55:48] = f[55:48] - 8'd1;
`endif
        return r;
    endfunction

    initial begin
        logic [63:0] f [3];
        logic [63:0] exp_hop;
        logic        m_so;
        logic [63:0] m_do;
        int          m_ptr;
        int          idx;
        logic [2:0]  exp_rr;
        logic        rst, en, ro;
        logic [2:0]  req;

        //           rst  en  req     ro  base    exp_rr  so    exp_do
        vecs.push_back('{1'b1, 1'b0, 3'b000, 1'b0, 64'h00, 3'b000, 1'b0, 64'h00});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 1'b0, 64'h00, 3'b000, 1'b0, 64'h00});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 64'hA5, 3'b001, 1'b1, 64'hA5});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 64'hA5, 3'b000, 1'b1, 64'hA5});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 64'hA5, 3'b000, 1'b1, 64'hA5});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 64'hA5, 3'b000, 1'b1, 64'hA5});
        vecs.push_back('{1'b0, 1'b1, 3'b101, 1'b1, 64'h20, 3'b100, 1'b1, 64'h22});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 1'b1, 64'h10, 3'b001, 1'b1, 64'h10});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 1'b1, 64'h10, 3'b010, 1'b1, 64'h11});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 1'b1, 64'h10, 3'b100, 1'b1, 64'h12});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 1'b1, 64'h10, 3'b001, 1'b1, 64'h10});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 1'b1, 64'h10, 3'b010, 1'b1, 64'h11});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 1'b1, 64'h10, 3'b100, 1'b1, 64'h12});
        vecs.push_back('{1'b0, 1'b0, 3'b010, 1'b1, 64'h30, 3'b000, 1'b1, 64'h12});
        vecs.push_back('{1'b0, 1'b0, 3'b010, 1'b1, 64'h30, 3'b000, 1'b1, 64'h12});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 1'b1, 64'h30, 3'b010, 1'b1, 64'h31});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 64'h30, 3'b000, 1'b0, 64'h31});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 1'b0, 64'h30, 3'b000, 1'b0, 64'h31});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 1'b0, 64'h40, 3'b001, 1'b1, 64'h40});
        vecs.push_back('{1'b1, 1'b1, 3'b111, 1'b0, 64'h50, 3'b000, 1'b0, 64'h00});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 1'b0, 64'h60, 3'b001, 1'b1, 64'h60});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 1'b1, 64'h60, 3'b010, 1'b1, 64'h61});

        $display("[TB] directed vector table, %0d entries", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].ro,
                          vecs[i].base, vecs[i].base + 64'd1, vecs[i].base + 64'd2);
            @(negedge clk);
            checkOutput($sformatf("vec%0d req_ri", i), {61'd0, req_ri}, {61'd0, vecs[i].exp_rr});
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d out_so", i), {63'd0, out_so}, {63'd0, vecs[i].exp_so});
            checkOutput($sformatf("vec%0d out_do", i), out_do, vecs[i].exp_do);
        end

        $display("[TB] hop field sequences");
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 64'h0, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1, 64'h7703_0000_0000_00AB, 64'h0, 64'h0);
        @(negedge clk);
        checkOutput("hop03 req_ri", {61'd0, req_ri}, 64'd1);
        @(posedge clk);
        #1;
`ifdef OUTPUT_ARBITER_HOP_DEC_EN
        exp_hop = 64'h7702_0000_0000_00AB;
`else
        exp_hop = 64'h7703_0000_0000_00AB;
`endif
        checkOutput("hop03 out_do", out_do, exp_hop);

        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1, 64'h8800_1234_5678_9ABC, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        checkOutput("hop00 out_do", out_do, 64'h8800_1234_5678_9ABC);
        checkOutput("hop00 out_so", {63'd0, out_so}, 64'd1);

        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1, 64'h00FF_0000_0000_0001, 64'h0, 64'h0);
        @(posedge clk);
        #1;
`ifdef OUTPUT_ARBITER_HOP_DEC_EN
        exp_hop = 64'h00FE_0000_0000_0001;
`else
        exp_hop = 64'h00FF_0000_0000_0001;
`endif
        checkOutput("hopFF out_do", out_do, exp_hop);

        $display("[TB] randomized traffic against reference model");
        m_so  = 1'b0;
        m_do  = 64'd0;
        m_ptr = 0;
        for (int n = 0; n < 400; n++) begin
            f[0] = {$urandom, $urandom};
            f[1] = {$urandom, $urandom};
            f[2] = {$urandom, $urandom};
            rst  = (n == 0) || ($urandom_range(0, 49) == 0);
            en   = ($urandom_range(0, 3) != 0);
            ro   = $urandom_range(0, 1) == 1;
            req  = 3'($urandom_range(0, 7));
            applyStimulus(rst, en, req, ro, f[0], f[1], f[2]);

            idx = -1;
            if (!rst && en && (!m_so || ro)) begin
                for (int k = 0; k < 3; k++) begin
                    if (idx < 0 && req[(m_ptr + k) % 3]) idx = (m_ptr + k) % 3;
                end
            end
            exp_rr = (idx >= 0) ? 3'(1 << idx) : 3'b000;

            @(negedge clk);
            checkOutput($sformatf("rnd%0d req_ri", n), {61'd0, req_ri}, {61'd0, exp_rr});
            if (n > 0) begin
                checkOutput($sformatf("rnd%0d out_so", n), {63'd0, out_so}, {63'd0, m_so});
                checkOutput($sformatf("rnd%0d out_do", n), out_do, m_do);
            end

            if (rst) begin
                m_so  = 1'b0;
                m_do  = 64'd0;
                m_ptr = 0;
            end else if (idx >= 0) begin
                m_so  = 1'b1;
                m_do  = model_store(f[idx]);
                m_ptr = (idx + 1) % 3;
            end else if (en && m_so && ro) begin
                m_so = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Three-input round-robin arbiter with a single-entry output register. It sits directly downstream of three input buffer stages (cw, ccw, pe) and drives one router output channel.
- Each input presents a 64-bit flit using the send/ready handshake. The block grants one requester per transfer, captures that flit and presents it downstream on the same send/ready handshake.
- Grants are fair. Back-to-back throughput is one flit per enabled cycle.

Parameters:
- DATA_W, 64, flit width in bits.
- HOP_LSB, 48, LSB of the 8-bit hop field within the flit. The field is bits [HOP_LSB+7:HOP_LSB] and is used only by the optional feature.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active high.
- arb_en  input  1  transfer enable (phase gate); no handshake completes while low.
- req_si  input  3  per-input valid from the upstream buffers: [0]=cw, [1]=ccw, [2]=pe.
- req_di  input  3*DATA_W  packed flits; input i occupies bits [i*DATA_W +: DATA_W].
- req_ri  output  3  per-input ready; at most one bit high. Connects to each upstream buffer's ready-out.
- out_so  output  1  output register holds a valid flit.
- out_ro  input  1  downstream ready.
- out_do  output  DATA_W  output flit, driven from the register at all times.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - out_so=0, out_do=0, rr_ptr=0 (rr_ptr is 2 bits).
  - req_ri=000 while reset is high.
  - Reset mid-transfer discards the held flit. No capture occurs on the reset edge.
- State: EMPTY (out_so=0) or FULL (out_so=1). out_so is the registered state bit.
- Combinational signals:
  - release = arb_en & out_so & out_ro
  - can_accept = arb_en & (~out_so | out_ro)
  - grant = one-hot; the first i with req_si[i]=1, scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). grant=000 when there are no requests.
  - req_ri = grant & {3{can_accept}}
  - capture = |req_ri
- Sequential update:
  - capture: out_do <= selected flit; out_so <= 1; rr_ptr <= (granted index + 1) mod 3.
  - release & ~capture: out_so <= 0; out_do holds its value.
  - neither: all state holds.
- Latency: one cycle from capture to out_so=1 and out_do valid.
- Pass-through: FULL, out_ro=1, arb_en=1 and a request pending gives simultaneous release and capture. out_so stays 1, out_do updates, no bubble.
- Backpressure: FULL with out_ro=0 gives req_ri=000. The held flit and rr_ptr are stable. Inputs are not consumed.
- arb_en=0: req_ri=000, no release, all state holds regardless of out_ro or req_si.
- rr_ptr only advances on a capture. It never takes the value 3; if it does, that value is treated as 0.
- Fairness: with all three inputs continuously requesting, grants cycle 0,1,2,0,… Any requesting input is served within 3 captures.
- out_do is not cleared on release; consumers qualify it with out_so.

Optional Feature:
- Macro: OUTPUT_ARBITER_HOP_DEC_EN.
- Defined: on capture, the hop field of the stored flit = selected hop field − 1, saturating at 0. All other bits pass unchanged.
- Undefined: the flit is stored unmodified.
- Handshake timing is identical in both builds.

Test Plan:
- Reset, then single request:
  - Stimulus: reset=1 for 2 cycles. Check out_so=0, out_do=0, req_ri=000. Release reset, arb_en=1, req_si=001, flit0=64'hA5, out_ro=0.
  - Required: req_ri=001 in that cycle; next cycle out_so=1, out_do=64'hA5.
  - Backpressure: hold out_ro=0 for 3 cycles → req_ri=000, out_do stays 64'hA5.
- Round robin:
  - Stimulus: req_si=111 for 6 cycles, out_ro=1, arb_en=1, flits i = 64'h10+i.
  - Required: out_do sequence 10,11,12,10,11,12; out_so continuously 1; no bubble.
- Pointer skip:
  - Stimulus: rr_ptr=1 (after one grant to input 0), req_si=101.
  - Required: grant to input 2 (req_ri=100); rr_ptr becomes 0.
- Enable gating:
  - Stimulus: FULL, out_ro=1, req_si=010, arb_en=0 for 2 cycles.
  - Required: req_ri=000, out_so stays 1, out_do unchanged.
  - Then arb_en=1 → pass-through capture of input 1 in one cycle.
- Reset mid-operation:
  - Stimulus: FULL with out_ro=0, assert reset for one cycle with req_si=111.
  - Required: next cycle out_so=0, out_do=0, rr_ptr=0, nothing captured.
- Hop decrement (build with OUTPUT_ARBITER_HOP_DEC_EN):
  - Stimulus: captured hop field 8'h03.
  - Required: stored hop field 8'h02.
  - Stimulus: hop field 8'h00.
  - Required: stored hop field 8'h00.
  - Without the macro: stored hop field 8'h03 (unchanged).
